// File: rtl/spi_led_slave_pkg.sv
// Shared definitions for the SPI LED slave: FSM encodings and default word width.
package spi_led_slave_pkg;

    localparam int unsigned DEF_DATA_W = 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/spi_led_slave_sync.sv
// Multi-flop synchronizer with previous-value register; reports level, rise and fall.
module spi_led_slave_sync #(
    parameter int unsigned STAGES   = 2,
    parameter logic        IDLE_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic [STAGES:0]   fill_q;
    logic              armed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {STAGES{IDLE_VAL}};
            prev_q <= IDLE_VAL;
            fill_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
            fill_q <= {fill_q[STAGES-1:0], 1'b1};
        end
    end

    // Edges only count once both level and prev hold real pin samples, so the
    // reset value never fakes a transition after reset release.
    assign armed = fill_q[STAGES];
    assign level = sync_q[STAGES-1];
    assign rise  = armed & level & ~prev_q;
    assign fall  = armed & ~level & prev_q;

endmodule

// File: rtl/spi_led_slave.sv
// Mode-0 MSB-first SPI slave, oversampled in the clk domain, latching bytes onto LEDs.
module spi_led_slave
    import spi_led_slave_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              SCLK,
    input  logic              MOSI,
    input  logic              SS,
    output logic [DATA_W-1:0] leds,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic [CNT_W-1:0]  byte_cnt,
    output logic              busy
);

    localparam int unsigned BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    logic s_sclk, sclk_rise, sclk_fall;
    logic s_mosi, mosi_rise, mosi_fall;
    logic s_ss, ss_rise, ss_fall;
    logic unused_sync;

    logic [0:0]        state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] leds_q, leds_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;

    spi_led_slave_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .din(SCLK),
        .level(s_sclk), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_led_slave_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .din(MOSI),
        .level(s_mosi), .rise(mosi_rise), .fall(mosi_fall)
    );

    spi_led_slave_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_ss (
        .clk(clk), .reset(reset), .din(SS),
        .level(s_ss), .rise(ss_rise), .fall(ss_fall)
    );

    assign unused_sync = ^{s_sclk, sclk_fall, mosi_rise, mosi_fall, s_ss};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        leds_d      = leds_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        byte_cnt_d  = byte_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d    = ST_SHIFT;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    shift_d = {shift_q[DATA_W-2:0], s_mosi};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d  = '0;
                        leds_d     = shift_d;
                        rx_data_d  = shift_d;
                        rx_valid_d = 1'b1;
                        if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
                // A same-cycle edge is already folded into bit_cnt_d above.
                if (ss_rise) begin
                    state_d     = ST_IDLE;
                    frame_err_d = (bit_cnt_d != '0);
                    bit_cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            leds_q      <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            byte_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            leds_q      <= leds_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

    assign leds      = leds_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign byte_cnt  = byte_cnt_q;
    assign busy      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_spi_led_slave.sv
// Directed bench for spi_led_slave: emulates an SPI master with SCLK half period of 5 clk.
module tb_spi_led_slave;

    localparam int HALF = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       SCLK, MOSI, SS;
    logic [7:0] leds, rx_data;
    logic       rx_valid, frame_err, busy;
    logic [3:0] byte_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    logic [7:0] rx_log[$];
    logic [7:0] seq_bytes [5] = '{8'h03, 8'h08, 8'hAA, 8'h55, 8'hFF};

    spi_led_slave #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .SCLK(SCLK), .MOSI(MOSI), .SS(SS),
        .leds(leds), .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .byte_cnt(byte_cnt), .busy(busy)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt = valid_cnt + 1;
            rx_log.push_back(rx_data);
        end
        if (frame_err) err_cnt = err_cnt + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i >= 8 - n; i--) begin
            MOSI = b[i];
            wait_clk(HALF);
            SCLK = 1'b1;
            wait_clk(HALF);
            SCLK = 1'b0;
        end
    endtask

    task automatic frame_byte(input logic [7:0] b);
        SS = 1'b0;
        wait_clk(HALF);
        send_bits(b, 8);
        wait_clk(HALF);
        SS = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic test_reset;
        reset = 1'b0; SCLK = 1'b0; MOSI = 1'b0; SS = 1'b1;
        wait_clk(3);
        reset = 1'b1;
        wait_clk(5);
        n_checks++; if (leds !== 8'h00) begin n_fail++; $display("FAIL reset_leds got %h want 00", leds); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        n_checks++; if (byte_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_byte_cnt got %0d want 0", byte_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_single;
        int v0 = valid_cnt;
        int e0 = err_cnt;
        frame_byte(8'hFA);
        n_checks++; if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL single_pulses got %0d want 1", valid_cnt - v0); end
        n_checks++; if (rx_data !== 8'hFA) begin n_fail++; $display("FAIL single_rx_data got %h want fa", rx_data); end
        n_checks++; if (leds !== 8'hFA) begin n_fail++; $display("FAIL single_leds got %h want fa", leds); end
        n_checks++; if (byte_cnt !== 4'd1) begin n_fail++; $display("FAIL single_byte_cnt got %0d want 1", byte_cnt); end
        n_checks++; if (err_cnt != e0) begin n_fail++; $display("FAIL single_frame_err got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_sequence;
        int v0 = valid_cnt;
        for (int i = 0; i < 5; i++) begin
            frame_byte(seq_bytes[i]);
            n_checks++;
            if (valid_cnt - v0 != i + 1 || rx_log[rx_log.size() - 1] !== seq_bytes[i]) begin
                n_fail++;
                $display("FAIL seq_byte%0d got %h (pulses %0d) want %h (pulses %0d)", i,
                         rx_log[rx_log.size() - 1], valid_cnt - v0, seq_bytes[i], i + 1);
            end
        end
        n_checks++; if (leds !== 8'hFF) begin n_fail++; $display("FAIL seq_leds got %h want ff", leds); end
    endtask

    task automatic test_back_to_back;
        int v0 = valid_cnt;
        int l0 = rx_log.size();
        SS = 1'b0;
        wait_clk(HALF);
        send_bits(8'hAA, 8);
        send_bits(8'h55, 8);
        wait_clk(HALF);
        SS = 1'b1;
        wait_clk(2 * HALF);
        n_checks++; if (valid_cnt - v0 != 2) begin n_fail++; $display("FAIL b2b_pulses got %0d want 2", valid_cnt - v0); end
        n_checks++; if (rx_log[l0] !== 8'hAA) begin n_fail++; $display("FAIL b2b_first got %h want aa", rx_log[l0]); end
        n_checks++; if (leds !== 8'h55) begin n_fail++; $display("FAIL b2b_leds got %h want 55", leds); end
        n_checks++; if (byte_cnt !== 4'd2) begin n_fail++; $display("FAIL b2b_byte_cnt got %0d want 2", byte_cnt); end
    endtask

    task automatic test_abort;
        int v0 = valid_cnt;
        int e0 = err_cnt;
        SS = 1'b0;
        wait_clk(HALF);
        send_bits(8'hC3, 5);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_mid got %b want 1", busy); end
        wait_clk(HALF);
        SS = 1'b1;
        wait_clk(2 * HALF);
        n_checks++; if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL abort_err_pulses got %0d want 1", err_cnt - e0); end
        n_checks++; if (valid_cnt != v0) begin n_fail++; $display("FAIL abort_rx_valid got %0d want 0", valid_cnt - v0); end
        n_checks++; if (leds !== 8'h55) begin n_fail++; $display("FAIL abort_leds got %h want 55", leds); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        n_checks++; if (byte_cnt !== 4'd0) begin n_fail++; $display("FAIL abort_byte_cnt got %0d want 0", byte_cnt); end
    endtask

    task automatic test_idle_sclk;
        int v0 = valid_cnt;
        int e0 = err_cnt;
        send_bits(8'hA5, 8);
        send_bits(8'h3C, 8);
        wait_clk(2 * HALF);
        n_checks++; if (valid_cnt != v0) begin n_fail++; $display("FAIL idle_rx_valid got %0d want 0", valid_cnt - v0); end
        n_checks++; if (err_cnt != e0) begin n_fail++; $display("FAIL idle_frame_err got %0d want 0", err_cnt - e0); end
        n_checks++; if (leds !== 8'h55) begin n_fail++; $display("FAIL idle_leds got %h want 55", leds); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_byte;
        int v0;
        int e0;
        SS = 1'b0;
        wait_clk(HALF);
        send_bits(8'h5A, 4);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_pre got %b want 1", busy); end
        #3 reset = 1'b0;
        #1;
        n_checks++; if (leds !== 8'h00) begin n_fail++; $display("FAIL rstmid_leds got %h want 00", leds); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_rx_data got %h want 00", rx_data); end
        n_checks++; if (byte_cnt !== 4'd0) begin n_fail++; $display("FAIL rstmid_byte_cnt got %0d want 0", byte_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
        n_checks++; if ({rx_valid, frame_err} !== 2'b00) begin n_fail++; $display("FAIL rstmid_pulses got %b want 00", {rx_valid, frame_err}); end
        wait_clk(3);
        reset = 1'b1;
        // SS is still low: the in-progress frame must be ignored until a fresh SS fall.
        v0 = valid_cnt;
        e0 = err_cnt;
        send_bits(8'hFF, 8);
        wait_clk(HALF);
        n_checks++; if (valid_cnt != v0) begin n_fail++; $display("FAIL rstmid_stale_valid got %0d want 0", valid_cnt - v0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale_busy got %b want 0", busy); end
        SS = 1'b1;
        wait_clk(2 * HALF);
        frame_byte(8'h5A);
        n_checks++; if (leds !== 8'h5A) begin n_fail++; $display("FAIL rstmid_new_leds got %h want 5a", leds); end
        n_checks++; if (byte_cnt !== 4'd1) begin n_fail++; $display("FAIL rstmid_new_byte_cnt got %0d want 1", byte_cnt); end
        n_checks++; if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL rstmid_new_pulses got %0d want 1", valid_cnt - v0); end
        n_checks++; if (err_cnt != e0) begin n_fail++; $display("FAIL rstmid_new_err got %0d want 0", err_cnt - e0); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_sequence;
        test_back_to_back;
        test_abort;
        test_idle_sclk;
        test_reset_mid_byte;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
